// File: rtl/instr_encoder.sv
// Instruction encoder: converts MIPS-style instruction descriptors into 32-bit words
// and streams them as consecutive instruction-memory writes starting at BASE.
module instr_encoder #(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [15:0] count,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FULL = 2'b10} state_t;

    // 17 bits so that DEPTH = 65536 is still reachable
    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    function automatic logic [31:0] encode(
        input logic [3:0]  f_kind,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (f_kind)
            4'd0:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100000};
            4'd1:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100010};
            4'd2:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100100};
            4'd3:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100101};
            4'd4:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b101010};
            4'd5:    w = {6'b000000, f_rs, 15'h0000, 6'b001000};
            4'd6:    w = {6'b000010, f_tgt};
            4'd7:    w = {6'b000011, f_tgt};
            4'd8:    w = {6'b100011, f_rs, f_rt, f_imm};
            4'd9:    w = {6'b101011, f_rs, f_rt, f_imm};
            4'd10:   w = {6'b000100, f_rs, f_rt, f_imm};
            4'd11:   w = {6'b000101, f_rs, f_rt, f_imm};
            4'd12:   w = {6'b001000, f_rs, f_rt, f_imm};
            4'd13:   w = {6'b001100, f_rs, f_rt, f_imm};
            4'd14:   w = {6'b001101, f_rs, f_rt, f_imm};
            4'd15:   w = {6'b001010, f_rs, f_rt, f_imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t      state_r, state_s;
    logic        out_valid_r, out_valid_s;
    logic [31:0] out_addr_r, out_addr_s;
    logic [31:0] out_data_r, out_data_s;
    logic [31:0] waddr_r, waddr_s;
    logic [16:0] count_r, count_s;
    logic        err_r, err_s;
    logic        done_r;
    logic        in_ready_s, accept_s;

    // Next-state, handshake and output-register update logic
    always_comb begin
        state_s     = state_r;
        out_valid_s = out_valid_r;
        out_addr_s  = out_addr_r;
        out_data_s  = out_data_r;
        waddr_s     = waddr_r;
        count_s     = count_r;
        err_s       = err_r;
        in_ready_s  = (state_r == RUN) & (~out_valid_r | out_ready);
        accept_s    = in_valid & in_ready_s;

        // A drained word retires in every state; a new accept below may reload it
        if (out_valid_r & out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        case (state_r)
            IDLE, FULL: begin
                if (start) begin
                    state_s = RUN;
                    waddr_s = BASE;
                    count_s = 17'd0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (accept_s & ~kind[4]) begin
                    out_valid_s = 1'b1;
                    out_addr_s  = waddr_r;
                    out_data_s  = encode(kind[3:0], rs, rt, rd, imm, target);
                    waddr_s     = waddr_r + 32'd4;
                    count_s     = count_r + 17'd1;
                    if (count_s == DEPTH_C) begin
                        state_s = FULL;
                    end else begin
                        state_s = RUN;
                    end
                end else if (accept_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and output registers; reset discards any pending word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_addr_r  <= 32'h0000_0000;
            out_data_r  <= 32'h0000_0000;
            waddr_r     <= BASE;
            count_r     <= 17'd0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_data_r  <= out_data_s;
            waddr_r     <= waddr_s;
            count_r     <= count_s;
            err_r       <= err_s;
            done_r      <= (state_s == FULL);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;
    assign count     = count_r[15:0];
    assign done      = done_r;
    assign err       = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a transaction-level model predicts every output each cycle,
// and directed scenarios pin encodings, backpressure, full/restart, illegal kinds and reset.
module tb_instr_encoder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;
    localparam int OPT [16] = '{0, 0, 0, 0, 0, 0, 2, 3, 35, 43, 4, 5, 8, 12, 13, 10};
    localparam int FNT [6]  = '{32, 34, 36, 37, 42, 8};

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, out_valid, out_ready, done, err;
    logic [4:0]  kind, rs, rt, rd;
    logic [15:0] imm, count;
    logic [25:0] target;
    logic [31:0] out_addr, out_data;

    instr_encoder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    // model: mode 0 idle, 1 running, 2 full; one pending output word at most
    int          m_mode  = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_data  = 32'h0;
    logic [31:0] m_next  = BASE;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    bit          m_ready, m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_enc(input int k, input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [15:0] im,
                                          input logic [25:0] tg);
        logic [31:0] w;
        if (k < 5)       w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(FNT[k]);
        else if (k == 5) w = (32'(s) << 21) | 32'(FNT[5]);
        else if (k < 8)  w = (32'(OPT[k]) << 26) | 32'(tg);
        else             w = (32'(OPT[k]) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
        return w;
    endfunction

    // Per-cycle comparison on the falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            m_mode = 0; m_valid = 1'b0; m_addr = 32'h0; m_data = 32'h0;
            m_next = BASE; m_count = 0; m_err = 1'b0;
        end
        m_ready = (m_mode == 1) && (!m_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || !reset) begin
            chk("out_addr", out_addr, m_addr);
            chk("out_data", out_data, m_data);
        end
        chk("count", 32'(count), 32'(m_count));
        chk("err", 32'(err), 32'(m_err));
        chk("done", 32'(done), 32'(m_mode == 2));
        if (reset) begin
            if (out_valid && out_ready) begin
                wa.push_back(out_addr);
                wd.push_back(out_data);
            end
            m_acc = m_ready && in_valid;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (start && m_mode != 1) begin
                m_mode = 1; m_next = BASE; m_count = 0; m_err = 1'b0;
            end else if (m_acc) begin
                if (int'(kind) < 16) begin
                    m_valid = 1'b1;
                    m_addr  = m_next;
                    m_data  = m_enc(int'(kind), rs, rt, rd, imm, target);
                    m_next  = m_next + 32'd4;
                    m_count = m_count + 1;
                    if (m_count == DEPTH) m_mode = 2;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic send_try(input logic [4:0] k, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                            input int lim, output bit ok);
        int n;
        kind = k; rs = s; rt = t; rd = d; imm = im; target = tg;
        in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < lim) begin
            #1;
            ok = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
        bit ok;
        send_try(k, s, t, d, im, tg, 20, ok);
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        int acc_n;
        bit ok;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        kind = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0; target = 26'h0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // first ADD after start
        pulse_start();
        clear_log();
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_addr", out_addr, 32'h0000_0000);
        chk("add_data", out_data, 32'h0022_1820);
        chk("add_count", 32'(count), 32'd1);
        pulse_start();
        send(5'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        chk("start_in_run_ignored", out_addr, 32'h0000_0004);

        // encoding sequence LW, J, BEQ
        do_reset();
        pulse_start();
        clear_log();
        send(5'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        send(5'd6, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
        send(5'd10, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        step(); step();
        chk("seq_writes", 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk("seq_lw", wd[0], 32'h8FA8_0004);  chk("seq_lw_addr", wa[0], 32'h0);
            chk("seq_j", wd[1], 32'h0800_0010);   chk("seq_j_addr", wa[1], 32'h4);
            chk("seq_beq", wd[2], 32'h1022_FFFF); chk("seq_beq_addr", wa[2], 32'h8);
        end

        // backpressure
        do_reset();
        pulse_start();
        clear_log();
        out_ready = 1'b0;
        send(5'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        kind = 5'd3; rs = 5'd7; rt = 5'd8; rd = 5'd9; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_data_stable", out_data, 32'h0085_3022);
            step();
        end
        out_ready = 1'b1;
        send(5'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
        step(); step();
        chk("bp_writes", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("bp_first", wd[0], 32'h0085_3022);  chk("bp_first_addr", wa[0], 32'h0);
            chk("bp_second", wd[1], 32'h00E8_4825); chk("bp_second_addr", wa[1], 32'h4);
        end

        // fill to DEPTH, then restart
        do_reset();
        pulse_start();
        clear_log();
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            send_try(5'd0, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0, 3, ok);
            if (ok) acc_n++;
        end
        step();
        chk("full_accepts", 32'(acc_n), 32'd4);
        chk("full_writes", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wa.size() > i) chk("full_addr", wa[i], 32'(4 * i));
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        pulse_start();
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        clear_log();
        send(5'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        step(); step();
        chk("restart_writes", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) chk("restart_addr", wa[0], BASE);

        // illegal kind mid-stream
        do_reset();
        pulse_start();
        clear_log();
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(5'd20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'd1);
        send(5'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        step(); step();
        chk("illegal_writes", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) chk("illegal_no_gap", wa[1], 32'h4);
        send(5'd12, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0);
        send(5'd13, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0);
        pulse_start();
        chk("start_clears_err", 32'(err), 32'd0);

        // reset while a word is held
        do_reset();
        pulse_start();
        clear_log();
        out_ready = 1'b0;
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        kind = 5'd0; in_valid = 1'b1;
        repeat (4) step();
        chk("arst_idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk("arst_no_write", 32'(wa.size()), 32'd0);

        // every legal kind, checked by the model
        clear_log();
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) pulse_start();
            send(5'(i), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        end
        step(); step();
        chk("sweep_writes", 32'(wa.size()), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0000, the byte address of the first instruction written.
REQ-002 SHALL have parameter DEPTH, default 64, the maximum number of legal instructions written per program (1..2^16).
REQ-003 SHALL have one clock; reset is asynchronous and active-low (ports clk and reset).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a new program.
REQ-007 in_valid  input  1  the instruction descriptor is valid.
REQ-008 in_ready  output  1  the descriptor is accepted when in_valid and in_ready are both high.
REQ-009 kind  input  5  instruction mnemonic code (table in REQ-015).
REQ-010 rs, rt, rd  input  5 each  register fields.
REQ-011 imm  input  16  immediate or branch offset; target  input  26  jump target.
REQ-012 out_valid  output  1; out_ready  input  1; out_addr  output  32; out_data  output  32  instruction-memory write channel.
REQ-013 count  output  16  number of legal instructions accepted since start; done  output  1  high in FULL; err  output  1  sticky illegal-kind flag.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and FULL.
- IDLE to RUN on start.
- RUN to FULL on the accept that makes count equal DEPTH.
- FULL to RUN on start.
- start in RUN is ignored.
REQ-015 SHALL encode each kind as follows; fields not listed are 0.
- R-type, op 000000 with rs/rt/rd: 0 ADD funct 100000, 1 SUB 100010, 2 AND 100100, 3 OR 100101, 4 SLT 101010.
- 5 JR: op 000000, rs, funct 001000.
- 6 J: op 000010, target. 7 JAL: op 000011, target.
- I-type with rs/rt/imm: 8 LW 100011, 9 SW 101011, 10 BEQ 000100, 11 BNE 000101, 12 ADDI 001000, 13 ANDI 001100, 14 ORI 001101, 15 SLTI 001010.
REQ-016 SHALL drive in_ready = (state==RUN) & (~out_valid | out_ready); in_ready SHALL be 0 in IDLE and FULL.
REQ-017 SHALL, on a legal accept:
- load out_data with the encoded word and out_addr with the write-address register;
- set out_valid;
- add 4 to the write-address register (wrapping modulo 2^32);
- increment count by 1.
All of this SHALL complete in the same edge, giving 1-cycle latency from accept to out_valid.
REQ-018 SHALL, on an accept with kind >= 16: complete the handshake, write nothing, leave out_valid/addr/count unchanged, and set err.
REQ-019 SHALL hold out_valid, out_addr and out_data stable while out_valid & ~out_ready.
REQ-020 SHALL clear out_valid on out_valid & out_ready, unless a new accept occurs in the same cycle, in which case it reloads with the new word.
REQ-021 SHALL, on start (from IDLE or FULL):
- set the write-address register to BASE and count to 0;
- clear err;
- leave any pending out_valid word undisturbed so it still drains.
REQ-022 In FULL, SHALL still drain the last pending word and SHALL drive done=1.
REQ-023 SHALL emit out_addr values strictly in increasing word order, with no gaps and no duplicates, within one program.

Reset
REQ-024 While reset=0, SHALL force: state IDLE, out_valid 0, out_addr 0, out_data 0, write-address register BASE, count 0, err 0, done 0.
REQ-025 SHALL take effect asynchronously on reset assertion, including mid-transfer; a pending word SHALL be discarded and not written.
REQ-026 SHALL, after reset deassertion, stay in IDLE with in_ready=0 until start.

Verification
REQ-027 start; ADD rd=3 rs=1 rt=2 with out_ready=1 -> next cycle out_valid=1, out_addr=0x00000000, out_data=0x00221820, count=1.
REQ-028 Encoding, in sequence: LW rt=8 rs=29 imm=0x0004, then J target=0x0000010, then BEQ rs=1 rt=2 imm=0xFFFF -> 0x8FA80004 @0x0, 0x08000010 @0x4, 0x1022FFFF @0x8.
REQ-029 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_data stable, in_ready=0 for those cycles, no descriptor lost; after release, words emerge in order.
REQ-030 DEPTH=4: feed 6 legal descriptors -> exactly 4 writes at 0x0..0xC, done=1, in_ready=0; a further start -> writes resume at BASE with count=0.
REQ-031 kind=20 accepted mid-stream -> err=1, no write; the next ADD lands at the next address with no gap.
REQ-032 reset=0 asserted while out_valid=1 and out_ready=0 -> out_valid drops immediately and all REQ-024 values hold; no write occurs after release until start.
